// File: rtl/shift_reg_pkg.sv
// Shared constants and word type for the tapped delay line and its consumers.
package shift_reg_pkg;
    localparam int ADDR_W    = 6;
    localparam int MAX_DEPTH = 64;
    localparam int WORD_W    = 16;

    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/tap_mux.sv
// DEPTH:1 tap select; addresses past the last entry read as zero.
module tap_mux
    import shift_reg_pkg::*;
#(
    parameter int dataWidth = WORD_W,
    parameter int DEPTH     = MAX_DEPTH
) (
    input  logic [DEPTH-1:0][dataWidth-1:0] taps,
    input  logic [ADDR_W-1:0]               address,
    output logic [dataWidth-1:0]            dout
);

    // Compare-and-select per entry keeps the index width-clean for any DEPTH.
    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (address == ADDR_W'(i)) dout = taps[i];
        end
    end

endmodule

// File: rtl/shift_reg.sv
// Tapped shift register: din enters entry 0 on shift, any entry readable combinationally.
module shift_reg
    import shift_reg_pkg::*;
#(
    parameter int dataWidth = WORD_W,
    parameter int DEPTH     = MAX_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift,
    input  logic [dataWidth-1:0]  din,
    input  logic [ADDR_W-1:0]     address,
    output logic [dataWidth-1:0]  dout
);

    logic [DEPTH-1:0][dataWidth-1:0] e;

    // Reset wins over shift; the oldest word simply falls off the end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            e <= '0;
        end else if (shift) begin
            e[0] <= din;
            for (int i = 1; i < DEPTH; i++) e[i] <= e[i-1];
        end
    end

    tap_mux #(
        .dataWidth (dataWidth),
        .DEPTH     (DEPTH)
    ) u_tap_mux (
        .taps    (e),
        .address (address),
        .dout    (dout)
    );

endmodule

// File: tb/tb_shift_reg.sv
// Scoreboarded directed bench for shift_reg; a DEPTH=8 twin exercises out-of-range reads.
module tb_shift_reg;
    import shift_reg_pkg::*;

    typedef struct {
        string name;
        int    addr;
        word_t exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        shift;
    word_t       din;
    logic [5:0]  address;
    word_t       dout;
    word_t       dout8;

    chk_t q[$];
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   issued  = 0;
    int   checked = 0;

    always #5 clk = ~clk;

    shift_reg #(.dataWidth(16), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .shift(shift), .din(din), .address(address), .dout(dout)
    );

    shift_reg #(.dataWidth(16), .DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .shift(shift), .din(din), .address(address), .dout(dout8)
    );

    // Monitor: pops each expected tap value and compares both instances.
    initial begin
        chk_t  it;
        word_t exp8;
        forever begin
            #1;
            if (q.size() != 0) begin
                it = q.pop_front();
                n_cmp++;
                if (dout !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s addr=%0d got=%h want=%h", it.name, it.addr, dout, it.exp);
                end
                exp8 = (it.addr < 8) ? it.exp : 16'h0000;
                n_cmp++;
                if (dout8 !== exp8) begin
                    n_fail++;
                    $display("FAIL %s_d8 addr=%0d got=%h want=%h", it.name, it.addr, dout8, exp8);
                end
                checked++;
            end
        end
    end

    task automatic step(input logic r, input logic s, input word_t d);
        rst = r; shift = s; din = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int a, input word_t e);
        address = 6'(a);
        q.push_back('{nm, a, e});
        issued++;
        for (int t = 0; t < 50; t++) begin
            if (checked == issued) break;
            #1;
        end
        if (checked != issued) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout addr=%0d got=no_sample want=sample", nm, a);
            q.delete();
            checked = issued;
        end
    endtask

    initial begin
        rst = 1'b0; shift = 1'b1; din = 16'hAAAA; address = '0;

        // Reset held two edges with shift active; everything reads zero.
        step(1'b0, 1'b1, 16'hAAAA);
        step(1'b0, 1'b1, 16'hAAAA);
        rst = 1'b1; shift = 1'b0;
        for (int a = 0; a < 64; a++) chk("reset", a, 16'h0000);

        // Single push lands at address 0 only.
        step(1'b1, 1'b1, 16'h0001);
        shift = 1'b0;
        for (int a = 0; a < 64; a++) chk("single", a, (a == 0) ? 16'h0001 : 16'h0000);

        // Shift chain from a clean reset.
        step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 16'h0001);
        step(1'b1, 1'b1, 16'h0001);
        step(1'b1, 1'b1, 16'hFFFF);
        shift = 1'b0;
        chk("chain0", 0, 16'hFFFF);
        chk("chain1", 1, 16'h0001);
        chk("chain2", 2, 16'h0001);
        chk("chain3", 3, 16'h0000);
        // Address change with no clock edge between the two reads.
        step(1'b1, 1'b0, 16'h0000);
        chk("comb0", 0, 16'hFFFF);
        chk("comb2", 2, 16'h0001);

        // Hold: ten idle edges with din toggling.
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, (k % 2 == 0) ? 16'h00FF : 16'h1234);
        for (int a = 0; a < 64; a++)
            chk("hold", a, (a == 0) ? 16'hFFFF : (a <= 2) ? 16'h0001 : 16'h0000);

        // Full depth: 65 pushes, value 1 falls off the end.
        step(1'b0, 1'b0, 16'h0000);
        for (int v = 1; v <= 65; v++) step(1'b1, 1'b1, 16'(v));
        shift = 1'b0;
        chk("full0", 0, 16'd65);
        chk("full63", 63, 16'd2);
        for (int a = 0; a < 64; a++) chk("full", a, 16'(65 - a));

        // Reset priority over a simultaneous shift.
        step(1'b0, 1'b1, 16'h00FF);
        rst = 1'b1; shift = 1'b0;
        for (int a = 0; a < 64; a++) chk("rstprio", a, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
